uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 57 +++++
 tb/tb_uart_rx_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through byte FIFO behind a UART receiver, sticky overflow on drop.
// Optional registered almost_full output (count >= HWM) when UART_RX_FIFO_HWM_EN is defined.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW = 4,
    parameter int HWM = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_rdy,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          overflow,
`ifdef UART_RX_FIFO_HWM_EN
    output logic          almost_full,
`endif
    input  logic          ovf_clr
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          pop, push, drop;
    logic [AW:0]   count_nxt;
    assign out_valid = count != '0;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    // a full FIFO still accepts a byte when the head leaves in the same cycle
    assign push      = in_rdy & ((count != FULL) | pop);
    assign drop      = in_rdy & ~push;
    assign count_nxt = (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
    // storage array, contents need no reset
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;
    // pointers, occupancy and sticky overflow; a drop beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            overflow <= drop | (overflow & ~ovf_clr);
        end
`ifdef UART_RX_FIFO_HWM_EN
    localparam logic [AW:0] HWM_C = (AW+1)'(HWM);
    // almost_full tracks the occupancy that will hold after this edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) almost_full <= 1'b0;
        else almost_full <= count_nxt >= HWM_C;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, hand corner sequences and randomized queue-model check of uart_rx_fifo.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int HWM = 12;
    logic       clk = 0;
    logic       rst_n = 0;
    logic [7:0] in_data = 0;
    logic       in_rdy = 0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 0;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr = 0;
`ifdef UART_RX_FIFO_HWM_EN
    logic       almost_full;
`endif
    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(4), .HWM(HWM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_rdy(in_rdy),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .overflow(overflow),
`ifdef UART_RX_FIFO_HWM_EN
        .almost_full(almost_full),
`endif
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic [7:0] d;
        logic       rd;
        logic       clr;
        int         cnt;
        logic       vld;
        logic [7:0] dat;
        logic       ovf;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_af(input string name, input int occ);
`ifdef UART_RX_FIFO_HWM_EN
        chk(name, int'(almost_full), int'(occ >= HWM));
`endif
    endtask

    logic [7:0] q[$];
    logic       m_ovf;

    initial begin
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 8'h12, 1'b1, 1'b0, 1, 1'b1, 8'h12, 1'b0};
        tbl[4] = '{1'b1, 8'h34, 1'b1, 1'b0, 1, 1'b1, 8'h34, 1'b0};
        tbl[5] = '{1'b1, 8'h56, 1'b0, 1'b0, 2, 1'b1, 8'h34, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h56, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};

        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk_af("rst_af", 0);
        #12;
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[i]) begin
            in_rdy = tbl[i].rdy;
            in_data = tbl[i].d;
            out_ready = tbl[i].rd;
            ovf_clr = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].dat));
            chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
        end
        in_rdy = 0;
        out_ready = 0;
        ovf_clr = 0;

        for (int i = 0; i < DEPTH; i++) begin
            in_rdy = 1;
            in_data = 8'(i);
            tick();
            chk_af($sformatf("fill%0d_af", i), i + 1);
        end
        chk("full_count", int'(count), 16);
        chk("full_head", int'(out_data), 8'h00);
        chk("full_ovf", int'(overflow), 0);
        in_data = 8'hAA;
        tick();
        chk("drop_ovf", int'(overflow), 1);
        chk("drop_count", int'(count), 16);
        chk("drop_head", int'(out_data), 8'h00);
        in_data = 8'h55;
        out_ready = 1;
        tick();
        chk("pushpop_count", int'(count), 16);
        chk("pushpop_head", int'(out_data), 8'h01);
        out_ready = 0;
        in_data = 8'hAA;
        ovf_clr = 1;
        tick();
        chk("clr_drop_ovf", int'(overflow), 1);
        chk("clr_drop_count", int'(count), 16);
        in_rdy = 0;
        tick();
        chk("clr_ovf", int'(overflow), 0);
        ovf_clr = 0;
        out_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d", i), int'(out_data), (i < 15) ? i + 1 : 8'h55);
            tick();
        end
        chk("drained_count", int'(count), 0);
        chk("drained_valid", int'(out_valid), 0);

        q = {};
        m_ovf = 0;
        for (int n = 0; n < 400; n++) begin
            bit pop, full;
            in_rdy = $urandom_range(0, 99) < 60;
            in_data = 8'($urandom);
            out_ready = $urandom_range(0, 99) < ((n < 200) ? 40 : 65);
            ovf_clr = $urandom_range(0, 99) < 8;
            pop = q.size() != 0 && out_ready;
            full = q.size() == DEPTH;
            if (pop) void'(q.pop_front());
            if (in_rdy && (!full || pop)) q.push_back(in_data);
            m_ovf = (in_rdy && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
            tick();
            chk("rnd_count", int'(count), q.size());
            chk("rnd_valid", int'(out_valid), int'(q.size() != 0));
            if (q.size() != 0) chk("rnd_data", int'(out_data), int'(q[0]));
            chk("rnd_ovf", int'(overflow), int'(m_ovf));
            chk_af("rnd_af", q.size());
        end

        in_rdy = 0;
        ovf_clr = 0;
        out_ready = 1;
        repeat (20) tick();
        out_ready = 0;
        in_rdy = 1;
        repeat (5) tick();
        in_rdy = 0;
        chk("pre_rst_count", int'(count), 5);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_ovf", int'(overflow), 0);
        chk_af("async_rst_af", 0);
        @(negedge clk);
        rst_n = 1;
        in_rdy = 1;
        in_data = 8'h77;
        tick();
        in_rdy = 0;
        chk("post_rst_count", int'(count), 1);
        chk("post_rst_data", int'(out_data), 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
